// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the five-stage pipeline: stalls, flushes, forwarding, MUL handshake.
// Define PIPELINE_FORWARD_EN to build with EX-stage forwarding; without it every RAW dependency stalls.

module pipeline_control #(
    parameter int MUL_TIMEOUT = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            ifid_instruction,
    input  logic [4:0]             idex_rs,
    input  logic [4:0]             idex_rt,
    input  logic [4:0]             idex_rd,
    input  logic                   idex_reg_write,
    input  logic                   idex_mem_read,
    input  logic                   idex_is_mul,
    input  logic [4:0]             exmem_rd,
    input  logic                   exmem_reg_write,
    input  logic                   exmem_mem_read,
    input  logic [4:0]             memwb_rd,
    input  logic                   memwb_reg_write,
    input  logic                   branch_equal,
    input  logic                   mul_done,
    output logic                   pc_enable,
    output logic                   ifid_enable_in,
    output logic                   idex_enable,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   pc_src,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   mul_req,
    output logic                   mul_error,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // state      | meaning
    // RUN        | normal issue; hazards, branches and MUL evaluated
    // LOAD_STALL | a bubble was just inserted; evaluated exactly like RUN
    // MUL_WAIT   | pipeline frozen until mul_done or timeout
    // FLUSH      | slot after a redirect; normal enables, no new redirect
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MUL_WAIT   = 2'b10,
        FLUSH      = 2'b11
    } state_t;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    localparam int               TMR_W    = $clog2(MUL_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MUL_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] tmr;
    logic             timeout_fire;

    logic [5:0] opcode;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       is_beq;
    logic       is_j;
    logic       idex_hits;
    logic       exmem_hits;
    logic       memwb_hits;
    logic       load_use;
    logic       branch_hazard;
    logic       data_hazard;
    logic       unused_bits;

    function automatic logic reg_match(input logic [4:0] dst, input logic wr, input logic [4:0] src);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

    assign opcode  = ifid_instruction[31:26];
    assign ifid_rs = ifid_instruction[25:21];
    assign ifid_rt = ifid_instruction[20:16];
    assign is_beq  = (opcode == OP_BEQ);
    assign is_j    = (opcode == OP_J);

    assign idex_hits  = reg_match(idex_rd, idex_reg_write, ifid_rs)
                      | reg_match(idex_rd, idex_reg_write, ifid_rt);
    assign exmem_hits = reg_match(exmem_rd, exmem_reg_write, ifid_rs)
                      | reg_match(exmem_rd, exmem_reg_write, ifid_rt);
    assign memwb_hits = reg_match(memwb_rd, memwb_reg_write, ifid_rs)
                      | reg_match(memwb_rd, memwb_reg_write, ifid_rt);

    assign load_use      = idex_mem_read & idex_hits;
    // BEQ compares in ID, so even ALU results one stage ahead are too late for it
    assign branch_hazard = is_beq & (idex_hits | (exmem_mem_read & exmem_hits));

`ifdef PIPELINE_FORWARD_EN
    assign data_hazard = load_use | branch_hazard;
    assign unused_bits = ^{ifid_instruction[15:0], memwb_hits};
`else
    assign data_hazard = load_use | branch_hazard | idex_hits | exmem_hits | memwb_hits;
    assign unused_bits = ^{ifid_instruction[15:0], idex_rs, idex_rt};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_enable      = 1'b1;
        ifid_enable_in = 1'b1;
        idex_enable    = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        pc_src         = 1'b1;
        mul_req        = 1'b0;
        timeout_fire   = 1'b0;
        case (state)
            RUN, LOAD_STALL: begin
                if (idex_is_mul) begin
                    mul_req        = 1'b1;
                    pc_enable      = 1'b0;
                    ifid_enable_in = 1'b0;
                    idex_enable    = 1'b0;
                    state_next     = MUL_WAIT;
                end else if (data_hazard) begin
                    pc_enable      = 1'b0;
                    ifid_enable_in = 1'b0;
                    idex_flush     = 1'b1;
                    state_next     = LOAD_STALL;
                end else if ((is_beq && branch_equal) || is_j) begin
                    pc_src         = 1'b0;
                    ifid_flush     = 1'b1;
                    state_next     = FLUSH;
                end else begin
                    state_next     = RUN;
                end
            end
            FLUSH: begin
                state_next = RUN;
            end
            MUL_WAIT: begin
                // mul_done releases the pipeline in the same cycle, even on the timeout cycle
                if (mul_done) begin
                    state_next = RUN;
                end else begin
                    mul_req        = 1'b1;
                    pc_enable      = 1'b0;
                    ifid_enable_in = 1'b0;
                    idex_enable    = 1'b0;
                    if (tmr == TMR_W'(1)) begin
                        timeout_fire = 1'b1;
                        state_next   = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (!reset) begin
            state_next     = RUN;
            pc_enable      = 1'b0;
            ifid_enable_in = 1'b0;
            idex_enable    = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            pc_src         = 1'b1;
            mul_req        = 1'b0;
            timeout_fire   = 1'b0;
        end
    end

    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
`ifdef PIPELINE_FORWARD_EN
        if (reset) begin
            if (reg_match(exmem_rd, exmem_reg_write, idex_rs)) begin
                forward_a = 2'b10;
            end else if (reg_match(memwb_rd, memwb_reg_write, idex_rs)) begin
                forward_a = 2'b01;
            end
            if (reg_match(exmem_rd, exmem_reg_write, idex_rt)) begin
                forward_b = 2'b10;
            end else if (reg_match(memwb_rd, memwb_reg_write, idex_rt)) begin
                forward_b = 2'b01;
            end
        end
`endif
    end

    // Down-counter preloaded outside MUL_WAIT; reaching 1 marks the last allowed wait cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else if (state != MUL_WAIT) begin
            tmr <= TMR_LOAD;
        end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_error <= 1'b0;
        end else if (timeout_fire) begin
            mul_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!pc_enable && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Hazard and sequencing controller for the five-stage 32-bit pipeline. It watches the IF/ID instruction and the destination fields of the ID/EX, EX/MEM and MEM/WB stages, then drives the program counter and pipeline-register enables, the flush controls, `pc_src` and the EX-stage forwarding selects. It also sequences the multi-cycle multiplier through a request/done handshake and keeps a saturating stall counter for performance measurement.

## Interface
- `MUL_TIMEOUT`, 64: maximum number of MUL_WAIT cycles before the wait is abandoned.
- `STALL_CNT_W`, 16: width of the stall counter.

- `clk` input 1: clock; all state is updated on the rising edge.
- `reset` input 1: reset, asynchronous, active-low.
- `ifid_instruction` input 32: IF/ID instruction; opcode [31:26], rs [25:21], rt [20:16], funct [5:0].
- `idex_rs`, `idex_rt` input 5 each: ID/EX source registers.
- `idex_rd` input 5: ID/EX destination register.
- `idex_reg_write`, `idex_mem_read`, `idex_is_mul` input 1 each: ID/EX control bits.
- `exmem_rd` input 5, `exmem_reg_write` input 1, `exmem_mem_read` input 1: EX/MEM destination and control.
- `memwb_rd` input 5, `memwb_reg_write` input 1: MEM/WB destination and control.
- `branch_equal` input 1: ID-stage register compare result.
- `mul_done` input 1: multiplier result valid; single-cycle pulse.
- `pc_enable` output 1: program counter load enable.
- `ifid_enable_in` output 1: IF/ID register load enable.
- `idex_enable` output 1: ID/EX register load enable.
- `ifid_flush` output 1: loads a NOP into IF/ID.
- `idex_flush` output 1: loads a bubble into ID/EX.
- `pc_src` output 1: 1 selects PC+4; 0 selects the branch target.
- `forward_a`, `forward_b` output 2 each: 00 selects the register file, 10 selects EX/MEM, 01 selects MEM/WB.
- `mul_req` output 1: multiplier start/hold request.
- `mul_error` output 1: sticky timeout flag.
- `stall_count` output `STALL_CNT_W`: number of stalled cycles, saturating.

## Operation
- The block uses the codebase opcodes: LW 6'h23, SW 6'h2b, BEQ 6'h04, J 6'h02, R-type 6'h00. MULT is R-type with funct 6'h18.
- "Match" means the destination equals the source register, the stage's reg_write bit is 1, and the destination is not 0. Register 0 never matches.

**State machine (2-bit state): RUN, LOAD_STALL, MUL_WAIT, FLUSH.**
- **RUN, evaluated in priority order:**
  - MUL: `idex_is_mul` → MUL_WAIT.
  - Load-use: `idex_mem_read` and `idex_rd` matches IF/ID rs or rt → LOAD_STALL.
  - Branch-data hazard: IF/ID is BEQ, and either `idex_rd` matches rs/rt or EX/MEM is a load that matches rs/rt → LOAD_STALL.
  - Taken branch: IF/ID is BEQ, `branch_equal`=1, no hazard → `pc_src`=0, `ifid_flush`=1, go to FLUSH.
  - J: `pc_src`=0, `ifid_flush`=1, go to FLUSH.
  - Otherwise: all enables 1, no flush, `pc_src`=1.
- **Any stall cycle:** `pc_enable`=0, `ifid_enable_in`=0, `idex_flush`=1.
- **LOAD_STALL:** one stall cycle, then re-evaluate as RUN. If the hazard persists, stall again.
- **FLUSH:** one cycle with normal enables and no redirect, then return to RUN. It exists so that the stall counter and the branch decision never double-count.
- **MUL_WAIT:**
  - Outputs: `mul_req`=1, `pc_enable`=0, `ifid_enable_in`=0, `idex_enable`=0, `idex_flush`=0.
  - Exit on `mul_done` → RUN; the pipeline releases in the same cycle.
  - A cycle counter counts each MUL_WAIT cycle. When it reaches `MUL_TIMEOUT` without `mul_done`, set `mul_error` (sticky until reset) and return to RUN.
  - If `mul_done` arrives on the timeout cycle, it wins and no error is flagged.
- **Forwarding (EX stage, `FORWARD_EN` builds):**
  - `forward_a`=10 if `exmem_rd` matches `idex_rs`; otherwise 01 if `memwb_rd` matches; otherwise 00.
  - EX/MEM has priority over MEM/WB.
  - `forward_b` uses the same rules with `idex_rt`.
- **Stall counter:** `stall_count` increments on every cycle where `pc_enable`=0 while reset is deasserted, and saturates at all-ones.

## Timing
- Every control output is combinational from the current state and inputs, so it is valid in the same cycle. The state, timeout counter, `mul_error` and `stall_count` are registered.
- A load-use hazard costs exactly 1 bubble. A taken branch or J costs 1 flushed slot. A MUL costs one stall cycle per wait cycle until `mul_done`.
- **While `reset`=0:**
  - State is RUN; counters, `mul_error` and `stall_count` are 0.
  - `pc_enable`=0, `ifid_enable_in`=0, `idex_enable`=0.
  - `ifid_flush`=1, `idex_flush`=1.
  - `pc_src`=1, forwards=00, `mul_req`=0.
- **Reset asserted mid-MUL_WAIT:** `mul_req` drops immediately (asynchronously), any pending `mul_done` is ignored, and `mul_error` clears.
- **Simultaneous events:** a load-use stall and a taken branch in the same cycle resolve to the stall. The branch is re-evaluated after the stall.

## Configuration
- **`PIPELINE_FORWARD_EN` defined:** forwarding selects operate as described above; stalls occur only for load-use, branch-data hazards and MUL.
- **`PIPELINE_FORWARD_EN` undefined:**
  - `forward_a` and `forward_b` are tied to 00.
  - RUN stalls (LOAD_STALL path) whenever ID/EX, EX/MEM or MEM/WB matches IF/ID rs or rt, for any instruction type.
  - The stall repeats until no stage matches.

## Test plan
- **Load-use:** LW r3 in ID/EX (`idex_mem_read`=1, `idex_rd`=3), IF/ID ADD with rs=3 → one cycle with `pc_enable`=0 and `idex_flush`=1, `stall_count` 0→1, then RUN.
- **Forwarding:** `exmem_rd`=5 and `memwb_rd`=5 (both reg_write=1), `idex_rs`=5 → `forward_a`=10. Clear the EX/MEM match → 01. Set rd=0 → 00.
- **Taken BEQ:** no hazard, `branch_equal`=1 → `pc_src`=0 and `ifid_flush`=1 for one cycle, FLUSH, then RUN with `pc_src`=1.
- **MUL handshake:** `idex_is_mul`=1, `mul_done` pulsed after 10 cycles → `mul_req` high for 10 cycles with all enables 0, `stall_count`=10, `mul_error`=0.
- **MUL timeout:** with `MUL_TIMEOUT`=4 and no `mul_done` → return to RUN after 4 cycles with `mul_error`=1. Then assert `reset`=0 → `mul_error`=0 and `stall_count`=0.
- **Non-forwarding build:** without `PIPELINE_FORWARD_EN`, ADD r2 in MEM/WB and IF/ID rs=2 → 1 stall cycle, forwards stay 00.
